// File: rtl/gcn_aggregate_argmax.sv
// GCN aggregation back end: streams a COO edge list, accumulates transformed
// feature rows per destination node with saturation, then computes per-node argmax.
module gcn_aggregate_argmax #(
    parameter int NUM_OF_NODES   = 6,
    parameter int NUM_CLASSES    = 3,
    parameter int DOT_PROD_WIDTH = 16,
    parameter int MAX_EDGES      = 6,
    parameter int SYMMETRIC      = 0,
    parameter int ADD_SELF_LOOPS = 0,
    parameter int COO_BW         = (NUM_OF_NODES > 1) ? $clog2(NUM_OF_NODES) : 1,
    parameter int EDGE_BW        = (MAX_EDGES > 1) ? $clog2(MAX_EDGES) : 1,
    parameter int CLASS_BW       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          start,
    input  logic [$clog2(MAX_EDGES+1)-1:0]                num_edges,
    output logic [EDGE_BW-1:0]                            coo_address,
    input  logic [1:0][COO_BW-1:0]                        coo_in,
    output logic [COO_BW-1:0]                             xw_row_addr,
    input  logic [NUM_CLASSES-1:0][DOT_PROD_WIDTH-1:0]    xw_row_in,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          sat_flag,
    output logic                                          idx_err,
    output logic [NUM_OF_NODES-1:0][CLASS_BW-1:0]         max_addi_answer
);
    localparam int NE_BW = $clog2(MAX_EDGES + 1);
    localparam logic [NE_BW-1:0] MAX_E = NE_BW'(MAX_EDGES);

    typedef enum logic [2:0] {IDLE, EDGE_A, EDGE_B, SELF, ARGMAX, FIN} state_t;
    state_t state, state_nxt, after_edges;

    logic [NE_BW-1:0]          e_clamp, e_lat;
    logic [EDGE_BW-1:0]        edge_cnt;
    logic [COO_BW-1:0]         node_cnt, xw_addr_q, add_idx;
    logic [DOT_PROD_WIDTH-1:0] acc [NUM_OF_NODES][NUM_CLASSES];
    logic                      start_acc, last_edge, last_node, idx_ok, edge_advance, add_en;
    logic [NUM_CLASSES-1:0][DOT_PROD_WIDTH-1:0] add_row, sum_row, arg_row;
    logic [NUM_CLASSES-1:0]    sum_sat;
    logic [DOT_PROD_WIDTH-1:0] best_val;
    logic [CLASS_BW-1:0]       best_class;

    assign coo_address  = edge_cnt;
    assign e_clamp      = (num_edges > MAX_E) ? MAX_E : num_edges;
    assign start_acc    = (state == IDLE) && start;
    assign last_edge    = (int'(edge_cnt) + 1) == int'(e_lat);
    assign last_node    = int'(node_cnt) == (NUM_OF_NODES - 1);
    assign idx_ok       = (int'(coo_in[0]) < NUM_OF_NODES) && (int'(coo_in[1]) < NUM_OF_NODES);
    assign edge_advance = ((state == EDGE_A) && (SYMMETRIC == 0)) || (state == EDGE_B);
    assign after_edges  = (ADD_SELF_LOOPS != 0) ? SELF : ARGMAX;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (e_clamp != '0) ? EDGE_A : after_edges;
            EDGE_A:  if (SYMMETRIC != 0) state_nxt = EDGE_B;
                     else if (last_edge) state_nxt = after_edges;
            EDGE_B:  state_nxt = last_edge ? after_edges : EDGE_A;
            SELF:    if (last_node) state_nxt = ARGMAX;
            ARGMAX:  if (last_node) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Row read address is combinational off coo_in so the row arrives in the same cycle.
    always_comb begin
        xw_row_addr = xw_addr_q;
        add_idx     = '0;
        add_en      = 1'b0;
        case (state)
            EDGE_A: begin
                xw_row_addr = coo_in[0];
                add_idx     = coo_in[1];
                add_en      = idx_ok;
            end
            EDGE_B: begin
                xw_row_addr = coo_in[1];
                add_idx     = coo_in[0];
                add_en      = idx_ok && (coo_in[0] != coo_in[1]);
            end
            SELF: begin
                xw_row_addr = node_cnt;
                add_idx     = node_cnt;
                add_en      = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        add_row = '0;
        arg_row = '0;
        for (int n = 0; n < NUM_OF_NODES; n++) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                if (add_idx == COO_BW'(n))  add_row[c] = acc[n][c];
                if (node_cnt == COO_BW'(n)) arg_row[c] = acc[n][c];
            end
        end
        for (int c = 0; c < NUM_CLASSES; c++) begin
            {sum_sat[c], sum_row[c]} = {1'b0, add_row[c]} + {1'b0, xw_row_in[c]};
            if (sum_sat[c]) sum_row[c] = '1;
        end
        // Strict greater-than keeps ties on the lowest class index.
        best_class = '0;
        best_val   = arg_row[0];
        for (int c = 1; c < NUM_CLASSES; c++) begin
            if (arg_row[c] > best_val) begin
                best_val   = arg_row[c];
                best_class = CLASS_BW'(c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the accumulator array is a handful of flops, so it is cleared by reset like any register.
            for (int n = 0; n < NUM_OF_NODES; n++)
                for (int c = 0; c < NUM_CLASSES; c++) acc[n][c] <= '0;
            edge_cnt        <= '0;
            node_cnt        <= '0;
            e_lat           <= '0;
            xw_addr_q       <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            sat_flag        <= 1'b0;
            idx_err         <= 1'b0;
            max_addi_answer <= '0;
        end else begin
            xw_addr_q <= xw_row_addr;
            if (start_acc) begin
                for (int n = 0; n < NUM_OF_NODES; n++)
                    for (int c = 0; c < NUM_CLASSES; c++) acc[n][c] <= '0;
                edge_cnt        <= '0;
                node_cnt        <= '0;
                e_lat           <= e_clamp;
                busy            <= 1'b1;
                done            <= 1'b0;
                sat_flag        <= 1'b0;
                idx_err         <= 1'b0;
                max_addi_answer <= '0;
            end else begin
                if (edge_advance && !last_edge) edge_cnt <= edge_cnt + 1'b1;
                if (state == SELF) node_cnt <= last_node ? '0 : node_cnt + 1'b1;
                if ((state == EDGE_A || state == EDGE_B) && !idx_ok) idx_err <= 1'b1;
                if (add_en) begin
                    for (int n = 0; n < NUM_OF_NODES; n++)
                        if (add_idx == COO_BW'(n))
                            for (int c = 0; c < NUM_CLASSES; c++) acc[n][c] <= sum_row[c];
                    if (|sum_sat) sat_flag <= 1'b1;
                end
                if (state == ARGMAX) begin
                    for (int n = 0; n < NUM_OF_NODES; n++)
                        if (node_cnt == COO_BW'(n)) max_addi_answer[n] <= best_class;
                    if (last_node) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end else begin
                        node_cnt <= node_cnt + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_gcn_aggregate_argmax.sv
// Bench for gcn_aggregate_argmax: a default instance and a symmetric/self-loop instance,
// driven with directed and random graphs and compared against an arithmetic model.
module tb_gcn_aggregate_argmax;
    localparam int N = 6;
    localparam int C = 3;
    localparam int W = 16;
    localparam int BUDGET = 300;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic                  start_s    [2];
    logic [2:0]            ne_s       [2];
    logic [2:0]            coo_addr_s [2];
    logic [1:0][2:0]       coo_in_s   [2];
    logic [2:0]            xw_addr_s  [2];
    logic [C-1:0][W-1:0]   xw_in_s    [2];
    logic                  busy_s     [2];
    logic                  done_s     [2];
    logic                  sat_s      [2];
    logic                  ierr_s     [2];
    logic [N-1:0][1:0]     ans_s      [2];

    int coo_src [2][8];
    int coo_dst [2][8];
    int xw      [2][8][C];

    int n_tests = 0;
    int n_fail  = 0;
    int exp_ans [N];
    int exp_sat, exp_ierr, exp_lat;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            coo_in_s[i][0] = 3'(coo_src[i][coo_addr_s[i]]);
            coo_in_s[i][1] = 3'(coo_dst[i][coo_addr_s[i]]);
            for (int c = 0; c < C; c++) xw_in_s[i][c] = W'(xw[i][xw_addr_s[i]][c]);
        end
    end

    gcn_aggregate_argmax u_dut (
        .clk(clk), .reset(reset), .start(start_s[0]), .num_edges(ne_s[0]),
        .coo_address(coo_addr_s[0]), .coo_in(coo_in_s[0]),
        .xw_row_addr(xw_addr_s[0]), .xw_row_in(xw_in_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .sat_flag(sat_s[0]), .idx_err(ierr_s[0]),
        .max_addi_answer(ans_s[0])
    );

    gcn_aggregate_argmax #(.SYMMETRIC(1), .ADD_SELF_LOOPS(1)) u_dut_sym (
        .clk(clk), .reset(reset), .start(start_s[1]), .num_edges(ne_s[1]),
        .coo_address(coo_addr_s[1]), .coo_in(coo_in_s[1]),
        .xw_row_addr(xw_addr_s[1]), .xw_row_in(xw_in_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .sat_flag(sat_s[1]), .idx_err(ierr_s[1]),
        .max_addi_answer(ans_s[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint clampv(input longint v);
        if (v > 65535) begin
            exp_sat = 1;
            return 65535;
        end
        return v;
    endfunction

    // Instance 1 is the symmetric/self-loop build; instance 0 has neither.
    function automatic void model(input int inst, input int ne);
        longint acc [N][C];
        int e, s, d, best;
        for (int n = 0; n < N; n++) for (int c = 0; c < C; c++) acc[n][c] = 0;
        exp_sat  = 0;
        exp_ierr = 0;
        e = (ne > 6) ? 6 : ne;
        for (int i = 0; i < e; i++) begin
            s = coo_src[inst][i];
            d = coo_dst[inst][i];
            if (s >= N || d >= N) exp_ierr = 1;
            else begin
                for (int c = 0; c < C; c++) acc[d][c] = clampv(acc[d][c] + xw[inst][s][c]);
                if (inst == 1 && s != d)
                    for (int c = 0; c < C; c++) acc[s][c] = clampv(acc[s][c] + xw[inst][d][c]);
            end
        end
        if (inst == 1)
            for (int n = 0; n < N; n++)
                for (int c = 0; c < C; c++) acc[n][c] = clampv(acc[n][c] + xw[inst][n][c]);
        for (int n = 0; n < N; n++) begin
            best = 0;
            for (int c = 1; c < C; c++) if (acc[n][c] > acc[n][best]) best = c;
            exp_ans[n] = best;
        end
        exp_lat = 1 + e * (inst + 1) + ((inst == 1) ? N : 0) + N;
    endfunction

    task automatic clear_graph(input int inst);
        for (int r = 0; r < 8; r++) begin
            coo_src[inst][r] = 0;
            coo_dst[inst][r] = 0;
            for (int c = 0; c < C; c++) xw[inst][r][c] = 0;
        end
    endtask

    task automatic plan_graph(input int inst);
        clear_graph(inst);
        for (int r = 0; r < N; r++) begin
            coo_src[inst][r] = r;
            coo_dst[inst][r] = r;
            for (int c = 0; c < C; c++) xw[inst][r][c] = (c == r % 3) ? 100 : 1;
        end
    endtask

    // Start a run, optionally pulse start (with a different edge count) in cycle 3,
    // wait for done and compare everything against the model.
    task automatic do_run(input int inst, input int ne, input bit pulse_mid, input string name);
        int cyc;
        model(inst, ne);
        @(negedge clk);
        ne_s[inst]    = 3'(ne);
        start_s[inst] = 1'b1;
        @(negedge clk);
        start_s[inst] = 1'b0;
        cyc = 1;
        check({name, " busy1"}, 32'(busy_s[inst]), 1);
        while (!done_s[inst] && cyc < BUDGET) begin
            start_s[inst] = pulse_mid && (cyc == 3);
            if (pulse_mid && cyc == 3) ne_s[inst] = 3'd2;
            @(negedge clk);
            cyc++;
        end
        start_s[inst] = 1'b0;
        check({name, " latency"}, 32'(cyc), 32'(exp_lat));
        check({name, " busy_end"}, 32'(busy_s[inst]), 0);
        check({name, " sat"}, 32'(sat_s[inst]), 32'(exp_sat));
        check({name, " idx_err"}, 32'(ierr_s[inst]), 32'(exp_ierr));
        for (int n = 0; n < N; n++)
            check($sformatf("%s ans%0d", name, n), 32'(ans_s[inst][n]), 32'(exp_ans[n]));
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;
            ne_s[i]    = '0;
            clear_graph(i);
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst%0d flags", i), {busy_s[i], done_s[i], sat_s[i], ierr_s[i]}, 0);
            check($sformatf("rst%0d coo_addr", i), 32'(coo_addr_s[i]), 0);
            check($sformatf("rst%0d xw_addr", i), 32'(xw_addr_s[i]), 0);
            check($sformatf("rst%0d ans", i), 32'(ans_s[i]), 0);
        end
        reset = 1'b0;

        plan_graph(0);
        do_run(0, 6, 1'b0, "plan");
        check("plan ans_packed", 32'(ans_s[0]), 32'h924);
        repeat (2) @(negedge clk);
        check("plan done_held", 32'(done_s[0]), 1);

        clear_graph(0);
        coo_src[0][0] = 0; coo_dst[0][0] = 0;
        coo_src[0][1] = 1; coo_dst[0][1] = 1;
        xw[0][0][0] = 7; xw[0][0][1] = 7; xw[0][0][2] = 7;
        xw[0][1][0] = 3; xw[0][1][1] = 9; xw[0][1][2] = 9;
        do_run(0, 2, 1'b0, "ties");

        clear_graph(0);
        coo_src[0][0] = 0; coo_dst[0][0] = 1;
        coo_src[0][1] = 0; coo_dst[0][1] = 1;
        xw[0][0][0] = 40000; xw[0][0][2] = 1;
        do_run(0, 2, 1'b0, "sat");

        clear_graph(1);
        for (int r = 2; r < N; r++) for (int c = 0; c < C; c++) xw[1][r][c] = $urandom_range(0, 50);
        coo_src[1][0] = 0; coo_dst[1][0] = 1;
        xw[1][0][0] = 1; xw[1][0][1] = 5;
        xw[1][1][0] = 4;
        do_run(1, 1, 1'b0, "sym");

        clear_graph(0);
        coo_src[0][0] = 7; coo_dst[0][0] = 2;
        coo_src[0][1] = 1; coo_dst[0][1] = 2;
        for (int c = 0; c < C; c++) xw[0][7][c] = 1000;
        xw[0][1][2] = 5;
        do_run(0, 2, 1'b0, "idx");

        do_run(0, 0, 1'b0, "zero_edges");
        plan_graph(0);
        do_run(0, 7, 1'b0, "clamp");
        do_run(0, 6, 1'b1, "mid_start");

        for (int it = 0; it < 12; it++) begin
            int inst;
            inst = it % 2;
            clear_graph(inst);
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < C; c++)
                    xw[inst][r][c] = ($urandom_range(0, 3) == 0) ? $urandom_range(30000, 65535)
                                                                  : $urandom_range(0, 200);
            for (int e = 0; e < 6; e++) begin
                coo_src[inst][e] = ($urandom_range(0, 7) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
                coo_dst[inst][e] = $urandom_range(0, 5);
            end
            do_run(inst, $urandom_range(0, 7), 1'b0, $sformatf("rand%0d", it));
        end

        plan_graph(0);
        @(negedge clk);
        ne_s[0]    = 3'd6;
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("abort coo_addr_c4", 32'(coo_addr_s[0]), 3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort flags", {busy_s[0], done_s[0], sat_s[0], ierr_s[0], done_s[1]}, 0);
        check("abort coo_addr", 32'(coo_addr_s[0]), 0);
        check("abort xw_addr", 32'(xw_addr_s[0]), 0);
        check("abort ans", {ans_s[0], ans_s[1]}, 0);
        do_run(0, 6, 1'b0, "after_abort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
